// File: rtl/delay_slot_cand_queue.sv
// Candidate queue feeding the delay-slot scheduler: presents head/head+1, applies pop/extract/NOP decisions.
// Optional macro DSQ_WAIT_TIMEOUT_EN: after WAIT_LIMIT consecutive waits the next wait issues a NOP slot.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0000
`endif

module delay_slot_cand_queue #(
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 3,
  parameter int WAIT_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        flush,
  input  logic        deq,
  input  logic        dec_valid,
  input  logic        dec_manual,
  input  logic        dec_auto,
  input  logic        dec_wait,
  input  logic        dec_nop,
  output logic        cand0_valid,
  output logic [31:0] cand0_instr,
  output logic [31:0] cand0_pc,
  output logic        cand1_valid,
  output logic [31:0] cand1_instr,
  output logic [31:0] cand1_pc,
  output logic        slot_valid,
  output logic [31:0] slot_instr,
  output logic [31:0] slot_pc,
  output logic        slot_is_nop,
  output logic        stall
);

  if (DEPTH < 2 || WAIT_LIMIT < 1 || (2 ** CNT_W) <= DEPTH) begin : g_bad_params
    $error("delay_slot_cand_queue: invalid parameter set");
  end

  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      instr_d [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             slot_valid_q, slot_valid_d;
  logic [31:0]      slot_instr_q, slot_instr_d;
  logic [31:0]      slot_pc_q, slot_pc_d;
  logic             slot_is_nop_q, slot_is_nop_d;
  logic             stall_q, stall_d;

  logic             pick_man, pick_auto, pick_nop, pick_wait;
  logic             timeout_hit;
  logic             remove, rm_at1, enq;
  logic [CNT_W-1:0] wr_idx;

`ifdef DSQ_WAIT_TIMEOUT_EN
  localparam int WC_W = $clog2(WAIT_LIMIT + 1);
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;

  assign timeout_hit = (wait_cnt_q >= WC_W'(WAIT_LIMIT));

  always_comb begin
    wait_cnt_d = '0;
    if (!flush && pick_wait) wait_cnt_d = wait_cnt_q + WC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign fetch_ready = (count_q < CNT_W'(DEPTH));
  assign cand0_valid = (count_q != '0);
  assign cand1_valid = (count_q >= CNT_W'(2));
  assign cand0_instr = instr_q[0];
  assign cand0_pc    = pc_q[0];
  assign cand1_instr = instr_q[1];
  assign cand1_pc    = pc_q[1];
  assign slot_valid  = slot_valid_q;
  assign slot_instr  = slot_instr_q;
  assign slot_pc     = slot_pc_q;
  assign slot_is_nop = slot_is_nop_q;
  assign stall       = stall_q;

  // Decision decode: manual > auto > wait > nop; unsatisfiable manual/auto degrade to a NOP slot.
  always_comb begin
    pick_man  = 1'b0;
    pick_auto = 1'b0;
    pick_nop  = 1'b0;
    pick_wait = 1'b0;
    if (dec_valid) begin
      if (dec_manual) begin
        if (count_q != '0) pick_man = 1'b1;
        else               pick_nop = 1'b1;
      end else if (dec_auto) begin
        if (count_q >= CNT_W'(2)) pick_auto = 1'b1;
        else                      pick_nop  = 1'b1;
      end else if (dec_wait) begin
        if (timeout_hit) pick_nop  = 1'b1;
        else             pick_wait = 1'b1;
      end else if (dec_nop) begin
        pick_nop = 1'b1;
      end
    end
  end

  always_comb begin
    instr_d       = instr_q;
    pc_d          = pc_q;
    count_d       = count_q;
    slot_valid_d  = 1'b0;
    slot_instr_d  = slot_instr_q;
    slot_pc_d     = slot_pc_q;
    slot_is_nop_d = slot_is_nop_q;
    stall_d       = 1'b0;
    remove        = 1'b0;
    rm_at1        = 1'b0;
    enq           = fetch_valid && fetch_ready && !flush;

    if (flush) begin
      count_d = '0;
    end else begin
      if (pick_man) begin
        slot_valid_d  = 1'b1;
        slot_instr_d  = instr_q[0];
        slot_pc_d     = pc_q[0];
        slot_is_nop_d = (instr_q[0] == `INST_NOP);
        remove        = 1'b1;
      end else if (pick_auto) begin
        slot_valid_d  = 1'b1;
        slot_instr_d  = instr_q[1];
        slot_pc_d     = pc_q[1];
        slot_is_nop_d = (instr_q[1] == `INST_NOP);
        remove        = 1'b1;
        rm_at1        = 1'b1;
      end else if (pick_nop) begin
        slot_valid_d  = 1'b1;
        slot_instr_d  = `INST_NOP;
        slot_pc_d     = '0;
        slot_is_nop_d = 1'b1;
      end else if (pick_wait) begin
        stall_d = 1'b1;
      end else if (!dec_valid && deq && count_q != '0) begin
        remove = 1'b1;
      end

      // Extraction closes the gap at index 0 (pop) or 1 (hoist); entry[0] survives a hoist.
      if (remove) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          if (!(rm_at1 && i == 0)) begin
            instr_d[i] = instr_q[i+1];
            pc_d[i]    = pc_q[i+1];
          end
        end
        instr_d[DEPTH-1] = '0;
        pc_d[DEPTH-1]    = '0;
      end

      if (enq) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) begin
            instr_d[i] = fetch_instr;
            pc_d[i]    = fetch_pc;
          end
        end
      end

      count_d = count_q - CNT_W'(remove) + CNT_W'(enq);
    end
  end

  assign wr_idx = count_q - CNT_W'(remove);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      count_q       <= '0;
      slot_valid_q  <= 1'b0;
      slot_instr_q  <= `INST_NOP;
      slot_pc_q     <= '0;
      slot_is_nop_q <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      slot_valid_q  <= slot_valid_d;
      slot_instr_q  <= slot_instr_d;
      slot_pc_q     <= slot_pc_d;
      slot_is_nop_q <= slot_is_nop_d;
      stall_q       <= stall_d;
    end
  end

endmodule

// File: tb/tb_delay_slot_cand_queue.sv
// Bench for delay_slot_cand_queue: queue-based reference model, directed scenarios and randomized traffic.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0000
`endif

module tb_delay_slot_cand_queue;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = 3;
  localparam int WAIT_LIMIT = 4;
`ifdef DSQ_WAIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = `INST_NOP;
  localparam logic [31:0] IA = 32'hAAAA_0001, IB = 32'hBBBB_0002, IC = 32'hCCCC_0003;
  localparam logic [31:0] ID = 32'hDDDD_0004, IE = 32'hEEEE_0005;

  logic        clk = 1'b0, rst = 1'b1;
  logic        fetch_valid = 1'b0, flush = 1'b0, deq = 1'b0;
  logic [31:0] fetch_instr = '0, fetch_pc = '0;
  logic        dec_valid = 1'b0, dec_manual = 1'b0, dec_auto = 1'b0, dec_wait = 1'b0, dec_nop = 1'b0;
  logic        fetch_ready, cand0_valid, cand1_valid, slot_valid, slot_is_nop, stall;
  logic [31:0] cand0_instr, cand0_pc, cand1_instr, cand1_pc, slot_instr, slot_pc;

  int checks = 0, failures = 0;

  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;
  ent_t        mq[$];
  bit          m_sv, m_sn, m_stall;
  logic [31:0] m_si, m_sp;
  int          m_wcnt;

  delay_slot_cand_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .flush(flush), .deq(deq),
    .dec_valid(dec_valid), .dec_manual(dec_manual), .dec_auto(dec_auto), .dec_wait(dec_wait), .dec_nop(dec_nop),
    .cand0_valid(cand0_valid), .cand0_instr(cand0_instr), .cand0_pc(cand0_pc),
    .cand1_valid(cand1_valid), .cand1_instr(cand1_instr), .cand1_pc(cand1_pc),
    .slot_valid(slot_valid), .slot_instr(slot_instr), .slot_pc(slot_pc), .slot_is_nop(slot_is_nop),
    .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sv = 1'b0; m_stall = 1'b0; m_wcnt = 0;
  endtask

  // Next state of the queue/slot from the inputs currently driven.
  task automatic model_step();
    int n = mq.size();
    bit enq = fetch_valid && (n < DEPTH);
    bit take = 1'b0, nop_slot = 1'b0;
    ent_t e, ne;
    m_sv = 1'b0;
    if (flush) begin
      mq.delete(); m_stall = 1'b0; m_wcnt = 0;
      return;
    end
    m_stall = 1'b0;
    if (dec_valid) begin
      if (dec_manual) begin
        if (n >= 1) begin e = mq.pop_front(); take = 1'b1; end
        else nop_slot = 1'b1;
      end else if (dec_auto) begin
        if (n >= 2) begin e = mq[1]; mq.delete(1); take = 1'b1; end
        else nop_slot = 1'b1;
      end else if (dec_wait) begin
        if (TO_EN && m_wcnt == WAIT_LIMIT) nop_slot = 1'b1;
        else begin m_stall = 1'b1; m_wcnt++; end
      end else if (dec_nop) begin
        nop_slot = 1'b1;
      end
    end else if (deq && n > 0) begin
      void'(mq.pop_front());
    end
    if (!m_stall) m_wcnt = 0;
    if (take)     begin m_sv = 1'b1; m_si = e.instr; m_sp = e.pc; m_sn = (e.instr == NOP); end
    if (nop_slot) begin m_sv = 1'b1; m_si = NOP; m_sp = '0; m_sn = 1'b1; end
    if (enq) begin ne.instr = fetch_instr; ne.pc = fetch_pc; mq.push_back(ne); end
  endtask

  task automatic compare();
    int n = mq.size();
    chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, n < DEPTH});
    chk("cand0_valid", {31'd0, cand0_valid}, {31'd0, n >= 1});
    chk("cand1_valid", {31'd0, cand1_valid}, {31'd0, n >= 2});
    if (n >= 1) begin
      chk("cand0_instr", cand0_instr, mq[0].instr);
      chk("cand0_pc", cand0_pc, mq[0].pc);
    end
    if (n >= 2) begin
      chk("cand1_instr", cand1_instr, mq[1].instr);
      chk("cand1_pc", cand1_pc, mq[1].pc);
    end
    chk("slot_valid", {31'd0, slot_valid}, {31'd0, m_sv});
    if (m_sv) begin
      chk("slot_instr", slot_instr, m_si);
      chk("slot_pc", slot_pc, m_sp);
      chk("slot_is_nop", {31'd0, slot_is_nop}, {31'd0, m_sn});
    end
    chk("stall", {31'd0, stall}, {31'd0, m_stall});
  endtask

  // Called just after a falling edge: drive, clock once, check on the next falling edge.
  task automatic step(input bit fv, input logic [31:0] fi, input logic [31:0] fp,
                      input bit fl, input bit dq, input bit dv, input bit dm,
                      input bit da, input bit dw, input bit dn);
    fetch_valid = fv; fetch_instr = fi; fetch_pc = fp; flush = fl; deq = dq;
    dec_valid = dv; dec_manual = dm; dec_auto = da; dec_wait = dw; dec_nop = dn;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    step(1'b1, i, p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int burst = 0;
    bit exp_sv;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    chk("rst_cand0_valid", {31'd0, cand0_valid}, 32'd0);
    chk("rst_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("rst_slot_instr", slot_instr, NOP);
    chk("rst_slot_pc", slot_pc, 32'd0);
    chk("rst_slot_is_nop", {31'd0, slot_is_nop}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // Asynchronous reset in the middle of filling
    push(IA, 32'h200); push(IB, 32'h204); push(IC, 32'h208);
    chk("fill3_cand1_valid", {31'd0, cand1_valid}, 32'd1);
    fetch_valid = 1'b1; fetch_instr = ID; fetch_pc = 32'h20C;
    #2 rst = 1'b1;
    #1;
    chk("arst_cand0_valid", {31'd0, cand0_valid}, 32'd0);
    chk("arst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    chk("arst_slot_valid", {31'd0, slot_valid}, 32'd0);
    model_reset();
    fetch_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    compare();

    // Fill to full with fetch_valid held, fifth offer refused, deq reopens
    push(IA, 32'h300); push(IB, 32'h304); push(IC, 32'h308);
    chk("fill3_ready", {31'd0, fetch_ready}, 32'd1);
    push(ID, 32'h30C);
    chk("full_ready", {31'd0, fetch_ready}, 32'd0);
    push(IE, 32'h310);
    chk("full_cand0", cand0_instr, IA);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("deq_ready", {31'd0, fetch_ready}, 32'd1);
    chk("deq_cand0", cand0_instr, IB);
    do_flush();

    // Manual slot: head popped into the slot
    push(IA, 32'h104); push(IB, 32'h108);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("man_slot_valid", {31'd0, slot_valid}, 32'd1);
    chk("man_slot_instr", slot_instr, IA);
    chk("man_slot_pc", slot_pc, 32'h104);
    chk("man_cand0", cand0_instr, IB);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("man_pulse", {31'd0, slot_valid}, 32'd0);
    do_flush();

    // Auto slot: cand1 hoisted, remaining entries compacted
    push(IA, 32'h104); push(IB, 32'h108); push(IC, 32'h10C);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("auto_slot_instr", slot_instr, IB);
    chk("auto_slot_pc", slot_pc, 32'h108);
    chk("auto_cand0", cand0_instr, IA);
    chk("auto_cand1", cand1_instr, IC);
    chk("auto_cand1_pc", cand1_pc, 32'h10C);
    chk("auto_count2", {30'd0, cand1_valid, fetch_ready}, 32'd3);
    do_flush();

    // Held wait: stall, and with the timeout a forced NOP on the fifth wait
    push(IA, 32'h400);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_sv = TO_EN && (k % 5 == 0);
      chk("wait_stall", {31'd0, stall}, {31'd0, !exp_sv});
      chk("wait_slot_valid", {31'd0, slot_valid}, {31'd0, exp_sv});
      if (exp_sv) begin
        chk("wait_nop_flag", {31'd0, slot_is_nop}, 32'd1);
        chk("wait_nop_pc", slot_pc, 32'd0);
        chk("wait_nop_instr", slot_instr, NOP);
      end
    end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wait_release", {31'd0, stall}, 32'd0);
    do_flush();

    // Flush beats a simultaneous fetch and manual decision
    push(IA, 32'h500); push(IB, 32'h504);
    step(1'b1, IC, 32'h508, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("flush_slot_valid", {31'd0, slot_valid}, 32'd0);
    chk("flush_cand0_valid", {31'd0, cand0_valid}, 32'd0);
    chk("flush_ready", {31'd0, fetch_ready}, 32'd1);

    // Randomized traffic including wait bursts long enough to hit the timeout
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ri, rp;
      bit fv, fl, dq, dv, dm, da, dw, dn;
      ri = ($urandom % 8 == 0) ? NOP : $urandom;
      rp = $urandom & 32'hFFFF_FFFC;
      fv = ($urandom % 4) != 0;
      fl = ($urandom % 60) == 0;
      dq = ($urandom % 3) == 0;
      if (burst > 0) begin
        burst--;
        dv = 1'b1; dm = 1'b0; da = 1'b0; dw = 1'b1; dn = 1'b0;
      end else begin
        if ($urandom % 40 == 0) burst = $urandom_range(3, 7);
        dv = ($urandom % 4) == 0;
        dm = $urandom % 2; da = $urandom % 2; dw = $urandom % 2; dn = $urandom % 2;
      end
      step(fv, ri, rp, fl, dq, dv, dm, da, dw, dn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
